// File: rtl/pipelined_control_unit_if.sv
// Control-unit bus: ID-stage decode inputs and per-stage control outputs.
// illegal_cnt is present only when CTRL_ILLEGAL_CNT_EN is defined.
// master = datapath side driving ID fields; slave = the control unit.
interface pipelined_control_unit_if #(
  parameter int OPCODE_W   = 6,
  parameter int ALUOP_W    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 8
);
  logic                  id_valid;
  logic [OPCODE_W-1:0]   id_opcode;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic                  flush;
  logic                  hazard_stall;
  logic                  illegal_op;
  logic                  ex_valid;
  logic                  ex_regdst;
  logic                  ex_alusrc;
  logic [ALUOP_W-1:0]    ex_aluop;
  logic                  mem_valid;
  logic                  mem_memread;
  logic                  mem_memwrite;
  logic                  wb_valid;
  logic                  wb_regwrite;
  logic                  wb_memtoreg;
`ifdef CTRL_ILLEGAL_CNT_EN
  logic [CNT_W-1:0]      illegal_cnt;
`endif

  modport master (
    output id_valid, id_opcode, id_rs, id_rt, flush,
    input  hazard_stall, illegal_op,
    input  ex_valid, ex_regdst, ex_alusrc, ex_aluop,
    input  mem_valid, mem_memread, mem_memwrite,
    input  wb_valid, wb_regwrite, wb_memtoreg
`ifdef CTRL_ILLEGAL_CNT_EN
    , input illegal_cnt
`endif
  );

  modport slave (
    input  id_valid, id_opcode, id_rs, id_rt, flush,
    output hazard_stall, illegal_op,
    output ex_valid, ex_regdst, ex_alusrc, ex_aluop,
    output mem_valid, mem_memread, mem_memwrite,
    output wb_valid, wb_regwrite, wb_memtoreg
`ifdef CTRL_ILLEGAL_CNT_EN
    , output illegal_cnt
`endif
  );
endinterface

// File: rtl/pipelined_control_unit.sv
// MIPS 5-stage control: ID decode, load-use bubble, flush, illegal flag (+ counter with CTRL_ILLEGAL_CNT_EN).
// Latency: decoded word in EX 1 cycle after ID, MEM +1, WB +2; hazard_stall/illegal_op combinational.
// Backpressure: hazard_stall asks upstream to hold ID; EX/MEM/WB always advance.
module pipelined_control_unit #(
  parameter int OPCODE_W   = 6,
  parameter int ALUOP_W    = 2,
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 8
) (
  input  logic clk,
  input  logic rst_n,
  pipelined_control_unit_if.slave bus
);

  localparam logic [OPCODE_W-1:0] OP_LW  = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW  = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_J   = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_R   = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_ORI = OPCODE_W'(6'b001101);

  typedef struct packed {
    logic               valid;
    logic               regdst;
    logic               alusrc;
    logic [ALUOP_W-1:0] aluop;
    logic               memread;
    logic               memwrite;
    logic               regwrite;
    logic               memtoreg;
  } ex_t;

  typedef struct packed {
    logic valid;
    logic memread;
    logic memwrite;
    logic regwrite;
    logic memtoreg;
  } mem_t;

  typedef struct packed {
    logic valid;
    logic regwrite;
    logic memtoreg;
  } wb_t;

  ex_t                   dec;
  logic                  known;
  logic                  illegal;
  logic                  stall;
  ex_t                   ex_d, ex_q;
  logic [REG_ADDR_W-1:0] ex_rt_d, ex_rt_q;
  mem_t                  mem_q;
  wb_t                   wb_q;

  always_comb begin
    dec   = '0;
    known = 1'b1;
    case (bus.id_opcode)
      OP_LW: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.memread  = 1'b1;
        dec.memtoreg = 1'b1;
      end
      OP_SW: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
      end
      OP_J: begin
        dec.aluop    = ALUOP_W'(2'b01);
      end
      OP_R: begin
        dec.regdst   = 1'b1;
        dec.regwrite = 1'b1;
        dec.aluop    = ALUOP_W'(2'b10);
      end
      OP_ORI: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.aluop    = ALUOP_W'(2'b11);
      end
      default: known = 1'b0;
    endcase
  end

  assign illegal = bus.id_valid & ~known;

  // Only LW sets memread, so it identifies a load sitting in EX.
  assign stall = bus.id_valid & ex_q.valid & ex_q.memread & (ex_rt_q != '0) &
                 ((ex_rt_q == bus.id_rs) | (ex_rt_q == bus.id_rt));

  always_comb begin
    ex_d    = '0;
    ex_rt_d = '0;
    if (!bus.flush && !stall && bus.id_valid && known) begin
      ex_d       = dec;
      ex_d.valid = 1'b1;
      ex_rt_d    = bus.id_rt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q    <= '0;
      ex_rt_q <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
    end else begin
      ex_q           <= ex_d;
      ex_rt_q        <= ex_rt_d;
      mem_q.valid    <= ex_q.valid;
      mem_q.memread  <= ex_q.memread;
      mem_q.memwrite <= ex_q.memwrite;
      mem_q.regwrite <= ex_q.regwrite;
      mem_q.memtoreg <= ex_q.memtoreg;
      wb_q.valid     <= mem_q.valid;
      wb_q.regwrite  <= mem_q.regwrite;
      wb_q.memtoreg  <= mem_q.memtoreg;
    end
  end

  assign bus.hazard_stall = stall;
  assign bus.illegal_op   = illegal;
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_regdst    = ex_q.regdst;
  assign bus.ex_alusrc    = ex_q.alusrc;
  assign bus.ex_aluop     = ex_q.aluop;
  assign bus.mem_valid    = mem_q.valid;
  assign bus.mem_memread  = mem_q.memread;
  assign bus.mem_memwrite = mem_q.memwrite;
  assign bus.wb_valid     = wb_q.valid;
  assign bus.wb_regwrite  = wb_q.regwrite;
  assign bus.wb_memtoreg  = wb_q.memtoreg;

`ifdef CTRL_ILLEGAL_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  // Counts only illegal opcodes that actually leave ID, saturating at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (illegal && !bus.flush && !stall && (cnt_q != '1)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign bus.illegal_cnt = cnt_q;
`else
  // Without the counter, illegal_op is the only report of a bad opcode.
`endif

endmodule

// File: tb/tb_pipelined_control_unit.sv
// Directed bench for pipelined_control_unit: decode, pipeline latency, load-use, flush, illegal, reset.
module tb_pipelined_control_unit;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  pipelined_control_unit_if #(.OPCODE_W(6), .ALUOP_W(2), .REG_ADDR_W(5), .CNT_W(8)) bus ();

  pipelined_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .REG_ADDR_W(5), .CNT_W(8)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

`ifdef CTRL_ILLEGAL_CNT_EN
  pipelined_control_unit_if #(.OPCODE_W(6), .ALUOP_W(2), .REG_ADDR_W(5), .CNT_W(2)) bus2 ();
  assign bus2.id_valid  = bus.id_valid;
  assign bus2.id_opcode = bus.id_opcode;
  assign bus2.id_rs     = bus.id_rs;
  assign bus2.id_rt     = bus.id_rt;
  assign bus2.flush     = bus.flush;

  pipelined_control_unit #(.OPCODE_W(6), .ALUOP_W(2), .REG_ADDR_W(5), .CNT_W(2)) dut2 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus2)
  );
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [5:0] op, input logic [4:0] rs,
                       input logic [4:0] rt, input logic fl);
    bus.id_valid  = v;
    bus.id_opcode = op;
    bus.id_rs     = rs;
    bus.id_rt     = rt;
    bus.flush     = fl;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL rst_ex_valid got %b exp 0", bus.ex_valid); end
    checks++; if (bus.ex_aluop !== 2'b00) begin errors++; $display("FAIL rst_ex_aluop got %b exp 00", bus.ex_aluop); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid got %b exp 0", bus.mem_valid); end
    checks++; if (bus.wb_regwrite !== 1'b0) begin errors++; $display("FAIL rst_wb_regwrite got %b exp 0", bus.wb_regwrite); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL rst_hazard got %b exp 0", bus.hazard_stall); end
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL rst_illegal got %b exp 0", bus.illegal_op); end
`ifdef CTRL_ILLEGAL_CNT_EN
    checks++; if (bus.illegal_cnt !== 8'd0) begin errors++; $display("FAIL rst_cnt got %0d exp 0", bus.illegal_cnt); end
`endif
    tick();
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_lw();
    drive(1'b1, 6'b100011, 5'd1, 5'd5, 1'b0);
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL lw_illegal got %b exp 0", bus.illegal_op); end
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lw_ex_valid got %b exp 1", bus.ex_valid); end
    checks++; if (bus.ex_alusrc !== 1'b1) begin errors++; $display("FAIL lw_ex_alusrc got %b exp 1", bus.ex_alusrc); end
    checks++; if (bus.ex_aluop !== 2'b00) begin errors++; $display("FAIL lw_ex_aluop got %b exp 00", bus.ex_aluop); end
    checks++; if (bus.ex_regdst !== 1'b0) begin errors++; $display("FAIL lw_ex_regdst got %b exp 0", bus.ex_regdst); end
    tick();
    checks++; if (bus.mem_memread !== 1'b1) begin errors++; $display("FAIL lw_mem_memread got %b exp 1", bus.mem_memread); end
    checks++; if (bus.mem_memwrite !== 1'b0) begin errors++; $display("FAIL lw_mem_memwrite got %b exp 0", bus.mem_memwrite); end
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lw_ex_after got %b exp 0", bus.ex_valid); end
    tick();
    checks++; if (bus.wb_regwrite !== 1'b1) begin errors++; $display("FAIL lw_wb_regwrite got %b exp 1", bus.wb_regwrite); end
    checks++; if (bus.wb_memtoreg !== 1'b1) begin errors++; $display("FAIL lw_wb_memtoreg got %b exp 1", bus.wb_memtoreg); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL lw_wb_drain got %b exp 0", bus.wb_valid); end
  endtask

  task automatic test_load_use();
    drive(1'b1, 6'b100011, 5'd2, 5'd5, 1'b0);
    tick();
    drive(1'b1, 6'b000000, 5'd5, 5'd3, 1'b0);
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_stall got %b exp 1", bus.hazard_stall); end
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble got %b exp 0", bus.ex_valid); end
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_stall_release got %b exp 0", bus.hazard_stall); end
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_valid !== 1'b1) begin errors++; $display("FAIL lu_add_valid got %b exp 1", bus.ex_valid); end
    checks++; if (bus.ex_regdst !== 1'b1) begin errors++; $display("FAIL lu_add_regdst got %b exp 1", bus.ex_regdst); end
    checks++; if (bus.ex_aluop !== 2'b10) begin errors++; $display("FAIL lu_add_aluop got %b exp 10", bus.ex_aluop); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL lu_mem_bubble got %b exp 0", bus.mem_valid); end
    checks++; if (bus.wb_memtoreg !== 1'b1) begin errors++; $display("FAIL lu_wb_lw got %b exp 1", bus.wb_memtoreg); end
    // Match through rt rather than rs.
    drive(1'b1, 6'b100011, 5'd0, 5'd9, 1'b0);
    tick();
    drive(1'b1, 6'b101011, 5'd1, 5'd9, 1'b0);
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL lu_rt_stall got %b exp 1", bus.hazard_stall); end
    drive(1'b1, 6'b101011, 5'd1, 5'd8, 1'b0);
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL lu_nomatch got %b exp 0", bus.hazard_stall); end
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    tick();
  endtask

  task automatic test_zero_reg();
    drive(1'b1, 6'b100011, 5'd0, 5'd0, 1'b0);
    tick();
    drive(1'b1, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.hazard_stall !== 1'b0) begin errors++; $display("FAIL zr_stall got %b exp 0", bus.hazard_stall); end
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_regdst !== 1'b1) begin errors++; $display("FAIL zr_add_regdst got %b exp 1", bus.ex_regdst); end
    tick();
  endtask

  task automatic test_flush();
    drive(1'b1, 6'b001101, 5'd1, 5'd2, 1'b1);
    tick();
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL fl_ex_valid got %b exp 0", bus.ex_valid); end
    checks++; if (bus.ex_alusrc !== 1'b0) begin errors++; $display("FAIL fl_ex_alusrc got %b exp 0", bus.ex_alusrc); end
    checks++; if (bus.ex_aluop !== 2'b00) begin errors++; $display("FAIL fl_ex_aluop got %b exp 00", bus.ex_aluop); end
    drive(1'b1, 6'b001101, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_aluop !== 2'b11) begin errors++; $display("FAIL ori_ex_aluop got %b exp 11", bus.ex_aluop); end
    checks++; if (bus.ex_alusrc !== 1'b1) begin errors++; $display("FAIL ori_ex_alusrc got %b exp 1", bus.ex_alusrc); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL fl_mem_bubble got %b exp 0", bus.mem_valid); end
    tick();
    tick();
    checks++; if (bus.wb_regwrite !== 1'b1) begin errors++; $display("FAIL ori_wb_regwrite got %b exp 1", bus.wb_regwrite); end
    // flush and load-use together: flush kills, stall still visible.
    drive(1'b1, 6'b100011, 5'd0, 5'd7, 1'b0);
    tick();
    drive(1'b1, 6'b001101, 5'd7, 5'd4, 1'b1);
    checks++; if (bus.hazard_stall !== 1'b1) begin errors++; $display("FAIL flst_stall got %b exp 1", bus.hazard_stall); end
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL flst_ex_valid got %b exp 0", bus.ex_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(1'b1, 6'b000010, 5'd0, 5'd0, 1'b0);
    tick();
    checks++; if (bus.ex_aluop !== 2'b01) begin errors++; $display("FAIL bb_j_aluop got %b exp 01", bus.ex_aluop); end
    drive(1'b1, 6'b000000, 5'd1, 5'd2, 1'b0);
    tick();
    checks++; if (bus.ex_aluop !== 2'b10) begin errors++; $display("FAIL bb_r_aluop got %b exp 10", bus.ex_aluop); end
    checks++; if (bus.mem_valid !== 1'b1) begin errors++; $display("FAIL bb_j_mem_valid got %b exp 1", bus.mem_valid); end
    checks++; if (bus.mem_memread !== 1'b0) begin errors++; $display("FAIL bb_j_memread got %b exp 0", bus.mem_memread); end
    drive(1'b1, 6'b001101, 5'd3, 5'd4, 1'b0);
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_aluop !== 2'b11) begin errors++; $display("FAIL bb_ori_aluop got %b exp 11", bus.ex_aluop); end
    checks++; if (bus.wb_valid !== 1'b1) begin errors++; $display("FAIL bb_j_wb_valid got %b exp 1", bus.wb_valid); end
    checks++; if (bus.wb_regwrite !== 1'b0) begin errors++; $display("FAIL bb_j_wb_regwrite got %b exp 0", bus.wb_regwrite); end
    tick();
    checks++; if (bus.wb_regwrite !== 1'b1) begin errors++; $display("FAIL bb_r_wb_regwrite got %b exp 1", bus.wb_regwrite); end
    checks++; if (bus.wb_memtoreg !== 1'b0) begin errors++; $display("FAIL bb_r_wb_memtoreg got %b exp 0", bus.wb_memtoreg); end
    tick();
    tick();
  endtask

  task automatic test_illegal();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'b111111, 5'd0, 5'd0, 1'b0);
      checks++; if (bus.illegal_op !== 1'b1) begin errors++; $display("FAIL ill_flag_%0d got %b exp 1", i, bus.illegal_op); end
      tick();
      checks++; if (bus.ex_valid !== 1'b0) begin errors++; $display("FAIL ill_bubble_%0d got %b exp 0", i, bus.ex_valid); end
    end
    drive(1'b0, 6'b111111, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.illegal_op !== 1'b0) begin errors++; $display("FAIL ill_novalid got %b exp 0", bus.illegal_op); end
    tick();
    checks++; if (bus.wb_valid !== 1'b0) begin errors++; $display("FAIL ill_wb_valid got %b exp 0", bus.wb_valid); end
`ifdef CTRL_ILLEGAL_CNT_EN
    checks++; if (bus.illegal_cnt !== 8'd3) begin errors++; $display("FAIL ill_cnt3 got %0d exp 3", bus.illegal_cnt); end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 6'b111111, 5'd0, 5'd0, 1'b0);
      tick();
    end
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.illegal_cnt !== 8'd5) begin errors++; $display("FAIL ill_cnt5 got %0d exp 5", bus.illegal_cnt); end
    checks++; if (bus2.illegal_cnt !== 2'd3) begin errors++; $display("FAIL ill_cnt_sat got %0d exp 3", bus2.illegal_cnt); end
`endif
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 6'b101011, 5'd1, 5'd2, 1'b0);
    tick();
    drive(1'b0, 6'b000000, 5'd0, 5'd0, 1'b0);
    checks++; if (bus.ex_alusrc !== 1'b1) begin errors++; $display("FAIL sw_ex_alusrc got %b exp 1", bus.ex_alusrc); end
    tick();
    checks++; if (bus.mem_memwrite !== 1'b1) begin errors++; $display("FAIL sw_mem_memwrite got %b exp 1", bus.mem_memwrite); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus.mem_memwrite !== 1'b0) begin errors++; $display("FAIL rstm_memwrite got %b exp 0", bus.mem_memwrite); end
    checks++; if (bus.mem_valid !== 1'b0) begin errors++; $display("FAIL rstm_mem_valid got %b exp 0", bus.mem_valid); end
    checks++; if ({bus.ex_valid, bus.wb_valid} !== 2'b00) begin errors++; $display("FAIL rstm_valids got %b exp 00", {bus.ex_valid, bus.wb_valid}); end
    tick();
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if ({bus.mem_memwrite, bus.wb_regwrite, bus.wb_valid} !== 3'b000) begin
        errors++; $display("FAIL rstm_post_%0d got %b exp 000", i, {bus.mem_memwrite, bus.wb_regwrite, bus.wb_valid});
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_lw();
    test_load_use();
    test_zero_reg();
    test_flush();
    test_back_to_back();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
